// File: rtl/parity3_frame_tx_if.sv
// Word handshake between a 3-bit word producer and the parity frame transmitter.
// The producer drives valid/data; the transmitter answers with ready.
interface parity3_frame_tx_if;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface : parity3_frame_tx_if

// File: rtl/parity3_frame_tx.sv
// Serializes a 3-bit word as start, d0, d1, d2, parity, stop on a single line.
// Each frame bit is held for CLKS_PER_BIT cycles; one frame in flight at a time.
module parity3_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity3_frame_tx_if.slave     in_if,
  output logic                  tx,
  output logic                  busy,
  output logic                  parity_out,
  output logic                  frame_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    LAST_DATA_BIT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Same function as the SOP parity generator, selected by PARITY_ODD.
  function automatic logic parity3(input logic [2:0] w);
    logic x;
    x = w[2] ^ w[1] ^ w[0];
    if (PARITY_ODD) begin
      parity3 = ~x;
    end else begin
      parity3 = x;
    end
  endfunction

  function automatic logic line_level(
    input state_e     st,
    input logic [1:0] idx,
    input logic [2:0] word,
    input logic       par
  );
    logic lvl;
    case (st)
      S_IDLE:   lvl = 1'b1;
      S_START:  lvl = 1'b0;
      S_DATA: begin
        case (idx)
          2'd0:    lvl = word[0];
          2'd1:    lvl = word[1];
          2'd2:    lvl = word[2];
          default: lvl = 1'b1;
        endcase
      end
      S_PARITY: lvl = par;
      S_STOP:   lvl = 1'b1;
      default:  lvl = 1'b1;
    endcase
    line_level = lvl;
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      bit_idx_q, bit_idx_d;
  logic [2:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            frame_done_q, frame_done_d;
  logic            bit_end;

  assign bit_end = (timer_q == TIMER_LAST);

  // Next-state, bit timer and word latch; in_* only reach outputs through flops.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    data_d       = data_q;
    parity_d     = parity_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d   = {TW{1'b0}};
        bit_idx_d = 2'd0;
        if (in_if.in_valid) begin
          data_d   = in_if.in_data;
          parity_d = parity3(in_if.in_data);
          state_d  = S_START;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_START: begin
        if (bit_end) begin
          timer_d   = {TW{1'b0}};
          bit_idx_d = 2'd0;
          state_d   = S_DATA;
        end else begin
          timer_d   = timer_q + TW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          timer_d = {TW{1'b0}};
          if (bit_idx_q == LAST_DATA_BIT) begin
            bit_idx_d = 2'd0;
            state_d   = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          timer_d = {TW{1'b0}};
          state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          timer_d      = {TW{1'b0}};
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        timer_d   = {TW{1'b0}};
        bit_idx_d = 2'd0;
      end
    endcase

    // Line level is registered from the next state so tx changes on the same edge as the state.
    tx_d = line_level(state_d, bit_idx_d, data_d, parity_d);
  end

  // State register with synchronous active-low reset; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= {TW{1'b0}};
      bit_idx_q    <= 2'd0;
      data_q       <= 3'd0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_if.in_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign tx             = tx_q;
  assign parity_out     = parity_q;
  assign frame_done     = frame_done_q;

endmodule : parity3_frame_tx
